// File: rtl/npc_sequencer_if.sv
// npc_sequencer_if: request/status bundle between the hazard unit / D-stage
// compare logic (master) and the fetch PC sequencer (slave).
// Optional exception entry/return signals are present when NPC_EXC_EN is defined.
interface npc_sequencer_if;
  logic        stall;
  logic        br_take;
  logic [31:0] br_target;
  logic        j_take;
  logic [31:0] j_target;
  logic        jr_take;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        fetch_valid;
  logic        redirect_pending;
  logic        addr_err;
`ifdef NPC_EXC_EN
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] exc_pc;
`endif

  modport master (
`ifdef NPC_EXC_EN
    output exc_req, eret_req, epc,
    input  exc_pc,
`endif
    output stall, br_take, br_target, j_take, j_target, jr_take, jr_target,
    input  pc, pc_plus8, fetch_valid, redirect_pending, addr_err
  );

  modport slave (
`ifdef NPC_EXC_EN
    input  exc_req, eret_req, epc,
    output exc_pc,
`endif
    input  stall, br_take, br_target, j_take, j_target, jr_take, jr_target,
    output pc, pc_plus8, fetch_valid, redirect_pending, addr_err
  );
endinterface

// File: rtl/npc_sequencer.sv
// npc_sequencer: fetch-stage program counter for the P5 pipeline.
// Sequences PC+4 versus jr/j/branch redirects, honours hazard stalls and
// buffers a redirect that arrives while fetch is frozen (HELD state) so it is
// applied on release. Defining NPC_EXC_EN adds exception entry (exc_req) and
// return (eret_req) with the EXC_VECTOR parameter and the exc_pc output.
module npc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef NPC_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
  input  logic           clk,
  input  logic           reset,
  npc_sequencer_if.slave npc
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HELD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        addr_err_q, addr_err_d;
  logic        redir;
  logic [31:0] redir_tgt;
  logic        load_en;
  logic [31:0] load_tgt;
`ifdef NPC_EXC_EN
  logic [31:0] exc_pc_q, exc_pc_d;
`endif

  // Redirect select: jr outranks j, which outranks a taken branch.
  always_comb begin
    redir     = npc.jr_take | npc.j_take | npc.br_take;
    redir_tgt = npc.br_target;
    if (npc.jr_take)     redir_tgt = npc.jr_target;
    else if (npc.j_take) redir_tgt = npc.j_target;
  end

  // State register: every flop, synchronous reset to the boot PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      addr_err_q <= 1'b0;
`ifdef NPC_EXC_EN
      exc_pc_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      addr_err_q <= addr_err_d;
`ifdef NPC_EXC_EN
      exc_pc_q   <= exc_pc_d;
`endif
    end
  end

  // Next-state: PC sequencing, redirect buffering, exception override,
  // then word-alignment of whatever target gets loaded.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    load_en    = 1'b0;
    load_tgt   = redir_tgt;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!npc.stall) begin
          if (redir) load_en = 1'b1;
          else       pc_d    = pc_q + 32'd4;
        end else if (redir) begin
          pend_tgt_d = redir_tgt;
          state_d    = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!npc.stall) begin
          load_en    = 1'b1;
          load_tgt   = redir ? redir_tgt : pend_tgt_q;
          pend_tgt_d = '0;
          state_d    = ST_RUN;
        end else if (redir) begin
          pend_tgt_d = redir_tgt;
        end
      end
      default: state_d = ST_BOOT;
    endcase
`ifdef NPC_EXC_EN
    exc_pc_d = exc_pc_q;
    if (npc.exc_req) begin
      load_en    = 1'b0;
      pc_d       = EXC_VECTOR;
      exc_pc_d   = pc_q;
      pend_tgt_d = '0;
      state_d    = ST_RUN;
    end else if (npc.eret_req) begin
      load_en    = 1'b1;
      load_tgt   = npc.epc;
      pend_tgt_d = '0;
      state_d    = ST_RUN;
    end
`endif
    if (load_en) pc_d = {load_tgt[31:2], 2'b00};
    addr_err_d = load_en & (|load_tgt[1:0]);
  end

  // Outputs: registered PC, link value and state decodes.
  always_comb begin
    npc.pc               = pc_q;
    npc.pc_plus8         = pc_q + 32'd8;
    npc.fetch_valid      = (state_q != ST_BOOT);
    npc.redirect_pending = (state_q == ST_HELD);
    npc.addr_err         = addr_err_q;
`ifdef NPC_EXC_EN
    npc.exc_pc           = exc_pc_q;
`endif
  end

endmodule
